// File: rtl/data_mem_access_ctrl_if.sv
// Signal bundle between the memory access controller, its two requesters and the data BRAM.
interface data_mem_access_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              i_pl_req;
    logic              i_pl_we;
    logic [2:0]        i_pl_type;
    logic [ADDR_W-1:0] i_pl_addr;
    logic [31:0]       i_pl_wdata;
    logic              o_pl_stall;
    logic              o_pl_valid;
    logic [31:0]       o_pl_rdata;
    logic              o_pl_misalign;

    logic              i_dbg_req;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic              o_dbg_valid;
    logic [31:0]       o_dbg_rdata;

    logic              o_mem_en;
    logic [3:0]        o_mem_we;
    logic [ADDR_W-3:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    // A requester raises req and holds it until its one-cycle valid pulse, then drops or replaces it.
    modport slave (
        input  i_pl_req, i_pl_we, i_pl_type, i_pl_addr, i_pl_wdata,
        output o_pl_stall, o_pl_valid, o_pl_rdata, o_pl_misalign,
        input  i_dbg_req, i_dbg_addr,
        output o_dbg_valid, o_dbg_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_pl_req, i_pl_we, i_pl_type, i_pl_addr, i_pl_wdata,
        input  o_pl_stall, o_pl_valid, o_pl_rdata, o_pl_misalign,
        output i_dbg_req, i_dbg_addr,
        input  o_dbg_valid, o_dbg_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// Arbitrates pipeline and debug accesses onto a single-port data BRAM, applying
// load/store lane selection, write enables, data replication and load extension.
module data_mem_access_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    data_mem_access_ctrl_if.slave  bus,
    output logic [1:0]             o_fsm_state
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
    typedef enum logic {OWN_PL, OWN_DBG} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              store_q, store_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        lo_q, lo_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              pl_valid_q, pl_valid_d;
    logic              pl_mis_q, pl_mis_d;
    logic [31:0]       pl_rdata_q, pl_rdata_d;
    logic              dbg_valid_q, dbg_valid_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;

    logic              pl_is_byte, pl_is_half, pl_misaligned;
    logic              unused_dbg_lo;

    // Type encoding: [1:0]==00 byte, 01 half, anything else is a full word.
    assign pl_is_byte    = (bus.i_pl_type[1:0] == 2'b00);
    assign pl_is_half    = (bus.i_pl_type[1:0] == 2'b01);
    assign pl_misaligned = (pl_is_half && bus.i_pl_addr[0]) ||
                           (!pl_is_byte && !pl_is_half && (bus.i_pl_addr[1:0] != 2'b00));
    assign unused_dbg_lo = ^bus.i_dbg_addr[1:0];

    function automatic logic [3:0] we_mask(input logic [2:0] t, input logic [1:0] lo);
        if (t[1:0] == 2'b00)      we_mask = 4'b0001 << lo;
        else if (t[1:0] == 2'b01) we_mask = lo[1] ? 4'b1100 : 4'b0011;
        else                      we_mask = 4'b1111;
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] t, input logic [31:0] d);
        if (t[1:0] == 2'b00)      replicate = {4{d[7:0]}};
        else if (t[1:0] == 2'b01) replicate = {2{d[15:0]}};
        else                      replicate = d;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] t,
                                            input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (t)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'h0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'h0, h};
            default: extract = word;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        store_d     = store_q;
        type_d      = type_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pl_valid_d  = 1'b0;
        pl_mis_d    = 1'b0;
        pl_rdata_d  = pl_rdata_q;
        dbg_valid_d = 1'b0;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            S_IDLE: begin
                // Memory outputs are registered, so the ISSUE-cycle values are loaded here.
                if (bus.i_dbg_req) begin
                    owner_d    = OWN_DBG;
                    store_d    = 1'b0;
                    type_d     = 3'b011;
                    lo_d       = 2'b00;
                    state_d    = S_ISSUE;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.i_dbg_addr[ADDR_W-1:2];
                end else if (bus.i_pl_req) begin
                    owner_d = OWN_PL;
                    store_d = bus.i_pl_we;
                    type_d  = bus.i_pl_type;
                    lo_d    = bus.i_pl_addr[1:0];
                    if (pl_misaligned) begin
                        state_d    = S_DONE;
                        pl_valid_d = 1'b1;
                        pl_mis_d   = 1'b1;
                    end else begin
                        state_d    = S_ISSUE;
                        mem_en_d   = 1'b1;
                        mem_addr_d = bus.i_pl_addr[ADDR_W-1:2];
                        if (bus.i_pl_we) begin
                            mem_we_d    = we_mask(bus.i_pl_type, bus.i_pl_addr[1:0]);
                            mem_wdata_d = replicate(bus.i_pl_type, bus.i_pl_wdata);
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (store_q) begin
                    state_d    = S_DONE;
                    pl_valid_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 3'(READ_LAT);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_DBG) begin
                        dbg_valid_d = 1'b1;
                        dbg_rdata_d = bus.i_mem_rdata;
                    end else begin
                        pl_valid_d = 1'b1;
                        pl_rdata_d = extract(bus.i_mem_rdata, type_q, lo_q);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_PL;
            store_q     <= 1'b0;
            type_q      <= 3'b000;
            lo_q        <= 2'b00;
            cnt_q       <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            pl_valid_q  <= 1'b0;
            pl_mis_q    <= 1'b0;
            pl_rdata_q  <= 32'h0;
            dbg_valid_q <= 1'b0;
            dbg_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            type_q      <= type_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pl_valid_q  <= pl_valid_d;
            pl_mis_q    <= pl_mis_d;
            pl_rdata_q  <= pl_rdata_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign bus.o_pl_stall    = bus.i_pl_req && !(state_q == S_DONE && owner_q == OWN_PL);
    assign bus.o_pl_valid    = pl_valid_q;
    assign bus.o_pl_misalign = pl_mis_q;
    assign bus.o_pl_rdata    = pl_rdata_q;
    assign bus.o_dbg_valid   = dbg_valid_q;
    assign bus.o_dbg_rdata   = dbg_rdata_q;
    assign bus.o_mem_en      = mem_en_q;
    assign bus.o_mem_we      = mem_we_q;
    assign bus.o_mem_addr    = mem_addr_q;
    assign bus.o_mem_wdata   = mem_wdata_q;
    assign o_fsm_state       = state_q;
endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Bench for data_mem_access_ctrl: two instances (read latency 1 and 3) each backed by
// a BRAM model, checked against a byte-level reference memory and load/store rules.
module tb_data_mem_access_ctrl;
    localparam int AW = 10;
    localparam int NW = 1 << (AW - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]         pl_req, pl_we, dbg_req;
    logic [1:0][2:0]    pl_type;
    logic [1:0][AW-1:0] pl_addr, dbg_addr;
    logic [1:0][31:0]   pl_wdata;
    logic [1:0]         pl_stall, pl_valid, pl_mis, dbg_valid, mem_en;
    logic [1:0][31:0]   pl_rdata, dbg_rdata, mem_wdata;
    logic [1:0][3:0]    mem_we;
    logic [1:0][AW-3:0] mem_addr;
    logic [1:0][1:0]    fsm_state;

    logic        pk_en;
    int          pk_k, pk_a;
    logic [31:0] pk_d;

    logic [31:0] ref_mem [2][NW];
    logic [31:0] last_ld [2];
    logic [3:0]  obs_we;
    logic [31:0] obs_wd;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        for (int b = 0; b < 4; b++) merge[8*b +: 8] = we[b] ? wd[8*b +: 8] : old[8*b +: 8];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0]      mem_g [NW];
        logic [7:0][31:0] pipe_g;

        data_mem_access_ctrl_if #(.ADDR_W(AW)) bus ();
        assign bus.i_pl_req    = pl_req[g];
        assign bus.i_pl_we     = pl_we[g];
        assign bus.i_pl_type   = pl_type[g];
        assign bus.i_pl_addr   = pl_addr[g];
        assign bus.i_pl_wdata  = pl_wdata[g];
        assign bus.i_dbg_req   = dbg_req[g];
        assign bus.i_dbg_addr  = dbg_addr[g];
        assign bus.i_mem_rdata = pipe_g[LAT-1];
        assign pl_stall[g]     = bus.o_pl_stall;
        assign pl_valid[g]     = bus.o_pl_valid;
        assign pl_mis[g]       = bus.o_pl_misalign;
        assign pl_rdata[g]     = bus.o_pl_rdata;
        assign dbg_valid[g]    = bus.o_dbg_valid;
        assign dbg_rdata[g]    = bus.o_dbg_rdata;
        assign mem_en[g]       = bus.o_mem_en;
        assign mem_we[g]       = bus.o_mem_we;
        assign mem_addr[g]     = bus.o_mem_addr;
        assign mem_wdata[g]    = bus.o_mem_wdata;

        data_mem_access_ctrl #(.ADDR_W(AW), .READ_LAT(LAT)) dut (
            .i_clk       (clk),
            .i_reset     (rst),
            .bus         (bus),
            .o_fsm_state (fsm_state[g])
        );

        // BRAM model: read data appears LAT cycles after the enable edge and is then held.
        always @(posedge clk) begin
            if (pk_en && pk_k == g) mem_g[pk_a] <= pk_d;
            if (mem_en[g] && mem_we[g] != 4'b0000)
                mem_g[mem_addr[g]] <= merge(mem_g[mem_addr[g]], mem_wdata[g], mem_we[g]);
            pipe_g <= {pipe_g[6:0], mem_en[g] ? mem_g[mem_addr[g]] : pipe_g[0]};
        end
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] peek(input int k, input int a);
        return (k == 0) ? g_dut[0].mem_g[a] : g_dut[1].mem_g[a];
    endfunction

    function automatic int ref_size(input logic [2:0] t);
        case (t)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] t,
                                             input int a);
        logic [31:0] v;
        int sz;
        sz = ref_size(t);
        v  = word >> (8 * (a % 4));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (t == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (t == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input int k, input string tag);
        check({tag, "_valids"}, {29'h0, pl_valid[k], pl_mis[k], dbg_valid[k]}, 32'h0);
        check({tag, "_mem_ctl"}, {27'h0, mem_en[k], mem_we[k]}, 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr[k]), 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata[k], 32'h0);
        check({tag, "_pl_rdata"}, pl_rdata[k], 32'h0);
        check({tag, "_dbg_rdata"}, dbg_rdata[k], 32'h0);
        check({tag, "_state_idle"}, 32'(fsm_state[k]), 32'h0);
    endtask

    task automatic pl_access(input int k, input bit we, input logic [2:0] t, input int a,
                             input logic [31:0] d, input string tag);
        int lat, exp_lat, sz, off;
        bit mis, saw_en, stall_ok, stall_at_valid;
        logic [AW-3:0] seen_addr;
        logic [31:0] exp_wd;
        logic [3:0] exp_we;
        sz  = ref_size(t);
        off = a % 4;
        mis = (a % sz) != 0;
        exp_lat = mis ? 1 : (we ? 2 : lat_of(k) + 2);
        @(posedge clk);
        @(negedge clk);
        pl_req[k] = 1'b1; pl_we[k] = we; pl_type[k] = t;
        pl_addr[k] = AW'(a); pl_wdata[k] = d;
        lat = 0; saw_en = 0; stall_ok = 1; stall_at_valid = 1;
        obs_we = 4'h0; obs_wd = 32'h0; seen_addr = '0;
        while (lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (mem_en[k]) begin
                saw_en = 1; obs_we = mem_we[k]; obs_wd = mem_wdata[k]; seen_addr = mem_addr[k];
            end
            if (pl_valid[k]) begin
                stall_at_valid = pl_stall[k];
                break;
            end
            if (!pl_stall[k]) stall_ok = 0;
        end
        pl_req[k] = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_misalign"}, {31'h0, pl_mis[k]}, {31'h0, mis});
        check({tag, "_stall_hold"}, {31'h0, stall_ok}, 32'h1);
        check({tag, "_stall_drop"}, {31'h0, stall_at_valid}, 32'h0);
        check({tag, "_mem_touched"}, {31'h0, saw_en}, {31'h0, !mis});
        if (!mis) begin
            check({tag, "_word_addr"}, 32'(seen_addr), 32'(a / 4));
            exp_we = 4'h0;
            exp_wd = 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (b >= off && b < off + sz) exp_we[b] = 1'b1;
                    exp_wd[8*b +: 8] = d[8*(b % sz) +: 8];
                end
                check({tag, "_we"}, {28'h0, obs_we}, {28'h0, exp_we});
                check({tag, "_wdata"}, obs_wd, exp_wd);
                for (int i = 0; i < sz; i++)
                    ref_mem[k][a/4][8*(off+i) +: 8] = d[8*i +: 8];
            end else begin
                check({tag, "_we_load"}, {28'h0, obs_we}, 32'h0);
                last_ld[k] = ref_load(ref_mem[k][a/4], t, a);
            end
        end
        check({tag, "_rdata"}, pl_rdata[k], last_ld[k]);
    endtask

    task automatic dbg_read(input int k, input int a);
        int lat;
        @(posedge clk);
        @(negedge clk);
        dbg_req[k] = 1'b1; dbg_addr[k] = AW'(a);
        lat = 0;
        while (lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (dbg_valid[k]) break;
        end
        dbg_req[k] = 1'b0;
        check("dbg_latency", lat, lat_of(k) + 2);
        check("dbg_rdata", dbg_rdata[k], ref_mem[k][a/4]);
    endtask

    task automatic contention(input int k);
        int cyc, dbg_lat, pl_lat, a_dbg, a_pl;
        bit stall_ok;
        a_dbg = $urandom_range(0, NW * 4 - 1);
        a_pl  = $urandom_range(0, NW - 1) * 4;
        @(posedge clk);
        @(negedge clk);
        dbg_req[k] = 1'b1; dbg_addr[k] = AW'(a_dbg);
        pl_req[k] = 1'b1; pl_we[k] = 1'b0; pl_type[k] = 3'b011; pl_addr[k] = AW'(a_pl);
        cyc = 0; dbg_lat = 0; pl_lat = 0; stall_ok = 1;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (dbg_valid[k]) begin
                dbg_lat = cyc;
                check("contend_dbg_rdata", dbg_rdata[k], ref_mem[k][a_dbg/4]);
                dbg_req[k] = 1'b0;
            end
            if (pl_valid[k]) begin
                pl_lat = cyc;
                break;
            end
            if (!pl_stall[k]) stall_ok = 0;
        end
        pl_req[k] = 1'b0;
        last_ld[k] = ref_mem[k][a_pl/4];
        check("contend_dbg_first", dbg_lat, lat_of(k) + 2);
        check("contend_pl_after", pl_lat, 2 * (lat_of(k) + 2) + 1);
        check("contend_stall", {31'h0, stall_ok}, 32'h1);
        check("contend_pl_rdata", pl_rdata[k], last_ld[k]);
    endtask

    task automatic reset_in_wait(input int k);
        int lat, a;
        bit early_valid;
        a = $urandom_range(0, NW - 1) * 4;
        @(posedge clk);
        @(negedge clk);
        pl_req[k] = 1'b1; pl_we[k] = 1'b0; pl_type[k] = 3'b011; pl_addr[k] = AW'(a);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_quiet(k, "rst_wait");
        early_valid = 0;
        @(posedge clk); #1;
        if (pl_valid[k]) early_valid = 1;
        @(negedge clk);
        rst = 1'b0;
        last_ld[0] = 32'h0;
        last_ld[1] = 32'h0;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (pl_valid[k]) break;
        end
        pl_req[k] = 1'b0;
        last_ld[k] = ref_mem[k][a/4];
        check("rst_no_valid", {31'h0, early_valid}, 32'h0);
        check("rst_restart_latency", lat, lat_of(k) + 2);
        check("rst_restart_rdata", pl_rdata[k], last_ld[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int errs, a, sz;
        logic [2:0] t;
        rst = 1'b1;
        pl_req = '0; pl_we = '0; dbg_req = '0;
        pl_type = '0; pl_addr = '0; dbg_addr = '0; pl_wdata = '0;
        pk_en = 1'b0; pk_k = 0; pk_a = 0; pk_d = 32'h0;
        last_ld[0] = 32'h0; last_ld[1] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet(0, "reset0");
        check_quiet(1, "reset1");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < NW; w++) begin
                @(negedge clk);
                pk_en = 1'b1; pk_k = k; pk_a = w;
                pk_d = (w == 5) ? 32'h80F1_7F02 : $urandom;
                ref_mem[k][w] = pk_d;
            end
        end
        @(negedge clk);
        pk_en = 1'b0;

        for (int k = 0; k < 2; k++) begin
            pl_access(k, 0, 3'b000, 'h16, 0, "lb");
            check("lb_const", pl_rdata[k], 32'hFFFF_FFF1);
            pl_access(k, 0, 3'b100, 'h16, 0, "lbu");
            check("lbu_const", pl_rdata[k], 32'h0000_00F1);
            pl_access(k, 0, 3'b001, 'h16, 0, "lh");
            check("lh_const", pl_rdata[k], 32'hFFFF_80F1);
            pl_access(k, 0, 3'b101, 'h14, 0, "lhu");
            check("lhu_const", pl_rdata[k], 32'h0000_7F02);
            pl_access(k, 1, 3'b000, 'h09, 32'h0000_0F81, "sb");
            check("sb_const", {obs_we, obs_wd[31:4]}, {4'b0010, 28'h8181818});
            pl_access(k, 1, 3'b001, 'h0A, 32'h000F_8001, "sh");
            check("sh_const", {obs_we, obs_wd[31:4]}, {4'b1100, 28'h8001800});
            pl_access(k, 1, 3'b011, 'h0C, 32'h1234_5678, "sw");
            check("sw_const_we", {28'h0, obs_we}, 32'hF);
            pl_access(k, 0, 3'b001, 'h03, 0, "lh_mis");
            pl_access(k, 1, 3'b011, 'h06, 32'hDEAD_BEEF, "sw_mis");
            pl_access(k, 1, 3'b110, 'h10, 32'hA5A5_0FF0, "t110_store");
            check("t110_we", {28'h0, obs_we}, 32'hF);
            pl_access(k, 0, 3'b110, 'h10, 0, "t110_load");
            check("t110_rdata", pl_rdata[k], 32'hA5A5_0FF0);
            dbg_read(k, 'h17);

            for (int n = 0; n < 60; n++) begin
                if ($urandom_range(0, 4) == 0) begin
                    dbg_read(k, $urandom_range(0, NW * 4 - 1));
                end else begin
                    t  = 3'($urandom_range(0, 7));
                    sz = ref_size(t);
                    a  = $urandom_range(0, NW * 4 - 1);
                    if ($urandom_range(0, 3) != 0) a = a - (a % sz);
                    pl_access(k, 1'($urandom_range(0, 1)), t, a, $urandom, "rand");
                end
            end
            contention(k);
        end

        reset_in_wait(1);
        reset_in_wait(0);

        for (int k = 0; k < 2; k++) begin
            errs = 0;
            for (int w = 0; w < NW; w++) if (peek(k, w) !== ref_mem[k][w]) errs++;
            check("mem_final_words_wrong", errs, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_access_ctrl.md
Name: data_mem_access_ctrl

Overview:
- Sequences every access to the single-port data memory on behalf of two requesters: the pipeline MEM stage and the debug unit.
- Applies the load/store type of each access: byte/half/word lane selection, byte-write enables, write-data replication, and sign/zero extension of loads.
- Stalls the pipeline while its access is in flight and flags misaligned accesses.
- Sits between the MEM stage, the debug unit and the data BRAM.

Parameters:
ADDR_W, 10, byte-address width of requester addresses; memory word address is ADDR_W-2 bits
READ_LAT, 1, memory read latency in cycles from the o_mem_en edge to valid i_mem_rdata (legal range 1..7)

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_pl_req  in  1  pipeline access request, held until o_pl_valid
i_pl_we  in  1  1=store, 0=load
i_pl_type  in  3  000 B, 001 H, 011 W, 100 BU, 101 HU; 010/110/111 treated as W
i_pl_addr  in  ADDR_W  byte address
i_pl_wdata  in  32  store data, right-aligned
o_pl_stall  out  1  combinational: i_pl_req && !(state==DONE && owner==PL)
o_pl_valid  out  1  one-cycle completion pulse
o_pl_rdata  out  32  extended load data, held until the next pipeline load completes
o_pl_misalign  out  1  qualifies o_pl_valid: access rejected, memory untouched
i_dbg_req  in  1  debug word read request, held until o_dbg_valid
i_dbg_addr  in  ADDR_W  byte address; bits [1:0] ignored
o_dbg_valid  out  1  one-cycle completion pulse
o_dbg_rdata  out  32  raw memory word, held
o_mem_en  out  1  memory enable
o_mem_we  out  4  byte write enables; lane k = bits 8k+7:8k
o_mem_addr  out  ADDR_W-2  word address
o_mem_wdata  out  32  lane-replicated write data
i_mem_rdata  in  32  read data, valid READ_LAT cycles after the en edge

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Owner register: PL or DBG.
- All memory-side outputs are registered.
- Reset, asynchronous:
  - state=IDLE, owner=PL.
  - o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata = 0.
  - o_pl_valid, o_pl_misalign, o_dbg_valid = 0.
  - o_pl_rdata, o_dbg_rdata = 0.
  - An in-flight access is abandoned: no valid pulse follows, and a pending write is dropped if its ISSUE cycle has not completed.
- IDLE, request sampled at edge T:
  - If i_dbg_req: debug wins; no preemption once granted. Owner=DBG, go to ISSUE as a word read.
  - Else if i_pl_req: owner=PL.
    - Alignment check: H/HU need addr[0]=0; W needs addr[1:0]=0.
    - Misaligned: go straight to DONE with o_pl_misalign=1; memory untouched.
    - Aligned: go to ISSUE.
- ISSUE, one cycle:
  - o_mem_en=1; o_mem_addr = addr[ADDR_W-1:2].
  - Store write enables: B/BU give 0001 shifted left by addr[1:0]; H/HU give 0011 or 1100 by addr[1]; W gives 1111.
  - Store write data: byte replicated ×4, half replicated ×2, or word.
  - Store → DONE. Load → WAIT with counter = READ_LAT.
- WAIT:
  - o_mem_en=0, o_mem_we=0. Counter decrements each cycle.
  - i_mem_rdata is captured on the edge that ends the last WAIT cycle; the FSM then enters DONE.
- Load extraction:
  - Lane selected by addr[1:0] (byte) or addr[1] (half), little-endian.
  - B/H sign-extend; BU/HU zero-extend; W passes the word.
  - Debug reads return the unmodified word.
- DONE, one cycle:
  - The owner's valid pulse is asserted; o_pl_misalign is 1 only for a rejected access.
  - o_pl_stall falls this cycle if owner=PL.
  - Next state is always IDLE; requests are not sampled in DONE.
- Latency from the sampling edge T to the valid cycle:
  - misaligned T+1
  - store T+2
  - load T+READ_LAT+2
- While the debug unit owns the memory, o_pl_stall stays high for a requesting pipeline.
- Back-to-back requests: a request still held in the IDLE cycle after DONE starts a new access. Requesters must drop or replace the request on valid.

Test Plan:
1. Word 5 holds 0x80F17F02. LB addr 0x16 → o_pl_rdata 0xFFFFFFF1. LBU → 0x000000F1. LH addr 0x16 → 0xFFFF80F1. LHU addr 0x14 → 0x00007F02. Each valid arrives at T+3 with READ_LAT=1.
2. SB addr 0x09, wdata 0x00000F81 → o_mem_we 0010, o_mem_wdata 0x81818181. SH addr 0x0A, wdata 0x000F8001 → we 1100, wdata 0x80018001. SW addr 0x0C → we 1111. Each valid arrives at T+2.
3. LH addr 0x03, then SW addr 0x06 → o_pl_valid and o_pl_misalign at T+1, o_mem_en never asserted, memory contents unchanged.
4. i_dbg_req and i_pl_req rise in the same cycle → debug read completes first; o_pl_stall stays 1 through debug DONE; pipeline valid arrives 1 IDLE cycle later.
5. Type 110 with addr 0x10 → treated as LW/SW with we 1111. Rerun all loads with READ_LAT=3 → valid at T+5.
6. Assert i_reset during WAIT of a load → all outputs 0 immediately, no o_pl_valid, FSM in IDLE. After release with i_pl_req still held, the access restarts and completes normally.
